deque_cmd_conditioner: RTL and testbench
========================================

// Module: deque_cmd_conditioner
// PURPOSE
//   Upstream command stage for dual_deque. Turns raw, asynchronous push/pop/select
//   switch levels into clean single-cycle push/pop strobes and a stable select.
//   Each input is synchronised and debounced. Commands that would overflow a full
//   deque or underflow an empty one are blocked here, and a sticky error plus a
//   reject count record them.
// PARAMETERS
//   DEBOUNCE_CYCLES  4  consecutive stable synced cycles before a level is accepted (>=1)
//   REJ_W            8  width of saturating reject counter
// PORTS
//   clk          in   1      clock
//   rst_n        in   1      async active-low reset
//   raw_select   in   1      async switch: deque to target (0=s0, 1=s1)
//   raw_push     in   1      async button: push request (rising edge = one command)
//   raw_pop      in   1      async button: pop request (rising edge = one command)
//   s0_full      in   1      deque 0 full flag (from dual_deque)
//   s0_empty     in   1      deque 0 empty flag
//   s1_full      in   1      deque 1 full flag
//   s1_empty     in   1      deque 1 empty flag
//   err_clear    in   1      sync clear of err_sticky and rej_count
//   deque_select out  1      registered select to dual_deque
//   push         out  1      one-cycle push strobe
//   pop          out  1      one-cycle pop strobe
//   reject       out  1      one-cycle pulse: command blocked
//   err_sticky   out  1      set by any reject, held until err_clear
//   rej_count    out  REJ_W  saturating count of rejects
// BEHAVIOUR
//   Reset (async, rst_n=0): all outputs 0; sync flops, debounced levels, debounce
//     counters and pending flags 0; FSM=IDLE. Commands in flight are dropped.
//   Sync: each raw input passes through a 2-flop synchroniser.
//   Debounce: per input, a counter of width clog2(DEBOUNCE_CYCLES+1).
//     - It counts while the synced value differs from the debounced value.
//     - It resets to 0 when they match.
//     - When it reaches DEBOUNCE_CYCLES, the debounced value flips and the counter clears.
//   Edge detect: debounced push/pop rising edge sets pending_push/pending_pop.
//     Falling edges are ignored.
//   Latency: raw push rises and is held from edge k.
//     - Debounced high after edge k+2+DEBOUNCE_CYCLES.
//     - push=1 for exactly the cycle after edge k+3+DEBOUNCE_CYCLES (FSM in IDLE).
//   FSM states IDLE, SETTLE:
//     - IDLE, pending_push: uses the debounced select, which is latched to deque_select
//       on this edge.
//       - If the target deque is not full: push=1 next cycle.
//       - Else: reject=1 next cycle.
//       - Either way: clear pending_push, go to SETTLE.
//     - IDLE, pending_pop only: same as push, using the empty flag; drives pop/reject.
//     - Push and pop pending together: push first. Pop stays pending and issues after SETTLE.
//     - SETTLE: one cycle for the deque flags to update. Strobes are 0. Next state IDLE.
//     - Back-to-back commands are therefore spaced at least 2 cycles apart.
//     - A new edge during SETTLE is held pending and never lost.
//     - A second edge of the same kind while pending is merged (no queueing beyond 1).
//   deque_select: updates only on IDLE cycles with no pending command.
//     Otherwise it holds the value latched at issue time.
//   push, pop and reject are mutually exclusive, and each is high for one cycle only.
//   Reject: err_sticky<=1; rej_count increments and saturates at 2^REJ_W-1.
//   err_clear: clears err_sticky and rej_count next edge.
//     - If a reject occurs in the same cycle, the reject wins: sticky=1, count=1.
//   After reset release with a button already held, the debounced level starts at 0.
//     The held level is treated as a new press and issues after the normal latency.
// TESTING (DEBOUNCE_CYCLES=4)
//   1. Reset, raw_push 0->1 held 20 cycles, select=0, s0_full=0
//      -> push=1 for one cycle, 7 cycles after the rise; no reject.
//   2. raw_pop glitch high for 3 synced cycles then low -> no pop, no reject;
//      debounced level unchanged.
//   3. select=1, s1_empty=1, pop press -> reject=1 one cycle, pop=0,
//      err_sticky=1, rej_count=1; then err_clear -> both 0.
//   4. push and pop debounced edges in the same cycle, flags clear
//      -> push pulse, pop pulse exactly 2 cycles later; deque_select constant.
//   5. 300 rejected pushes (s0_full=1) -> rej_count saturates at 255;
//      err_clear with a coincident reject -> rej_count=1, err_sticky=1.
//   6. Assert rst_n=0 between debounce and strobe -> no strobe; after release with
//      the button still held, push issues 7 cycles later.

Source files
------------

// File: rtl/deque_cmd_conditioner.sv
// Command conditioner ahead of dual_deque: synchronises and debounces the switch inputs,
// issues guarded one-cycle push/pop strobes and records blocked commands.
module deque_cmd_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REJ_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             raw_select,
    input  logic             raw_push,
    input  logic             raw_pop,
    input  logic             s0_full,
    input  logic             s0_empty,
    input  logic             s1_full,
    input  logic             s1_empty,
    input  logic             err_clear,
    output logic             deque_select,
    output logic             push,
    output logic             pop,
    output logic             reject,
    output logic             err_sticky,
    output logic [REJ_W-1:0] rej_count
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    typedef enum logic {IDLE, SETTLE} state_t;

    // Bit 0 = select, bit 1 = push, bit 2 = pop.
    logic [2:0] raw_w;
    logic [2:0] sync1_q, sync2_q;
    logic [2:0] deb_q, deb_d;

    assign raw_w = {raw_pop, raw_push, raw_select};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
        end else begin
            sync1_q <= raw_w;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_deb
            logic [CW-1:0] cnt_q, cnt_d;
            logic          differ_w, flip_w;

            assign differ_w  = sync2_q[gi] != deb_q[gi];
            // The level flips on the cycle the counter is seen at its limit.
            assign flip_w    = differ_w && (cnt_q == CNT_MAX);
            assign deb_d[gi] = deb_q[gi] ^ flip_w;
            assign cnt_d     = (!differ_w || flip_w) ? '0 : cnt_q + CW'(1);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) cnt_q <= '0;
                else        cnt_q <= cnt_d;
            end
        end
    endgenerate

    logic   rise_push_w, rise_pop_w;
    logic   pend_push_q, pend_push_d, pend_pop_q, pend_pop_d;
    logic   clr_push, clr_pop;
    state_t state_q, state_d;
    logic   sel_q, sel_d;
    logic   push_q, push_d, pop_q, pop_d, reject_q, reject_d;
    logic   sticky_q, sticky_d;
    logic [REJ_W-1:0] cnt_rej_q, cnt_rej_d;
    logic   tgt_full_w, tgt_empty_w;

    assign rise_push_w = deb_d[1] & ~deb_q[1];
    assign rise_pop_w  = deb_d[2] & ~deb_q[2];
    assign tgt_full_w  = deb_q[0] ? s1_full  : s0_full;
    assign tgt_empty_w = deb_q[0] ? s1_empty : s0_empty;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        push_d   = 1'b0;
        pop_d    = 1'b0;
        reject_d = 1'b0;
        clr_push = 1'b0;
        clr_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                sel_d = deb_q[0];
                if (pend_push_q) begin
                    push_d   = !tgt_full_w;
                    reject_d = tgt_full_w;
                    clr_push = 1'b1;
                    state_d  = SETTLE;
                end else if (pend_pop_q) begin
                    pop_d    = !tgt_empty_w;
                    reject_d = tgt_empty_w;
                    clr_pop  = 1'b1;
                    state_d  = SETTLE;
                end
            end
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A fresh edge arriving as the old request is consumed stays pending.
        pend_push_d = (pend_push_q & ~clr_push) | rise_push_w;
        pend_pop_d  = (pend_pop_q  & ~clr_pop)  | rise_pop_w;

        sticky_d  = sticky_q;
        cnt_rej_d = cnt_rej_q;
        if (reject_d) begin
            sticky_d  = 1'b1;
            if (err_clear)              cnt_rej_d = REJ_W'(1);
            else if (cnt_rej_q != '1)   cnt_rej_d = cnt_rej_q + REJ_W'(1);
        end else if (err_clear) begin
            sticky_d  = 1'b0;
            cnt_rej_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pend_push_q <= 1'b0;
            pend_pop_q  <= 1'b0;
            sel_q       <= 1'b0;
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            reject_q    <= 1'b0;
            sticky_q    <= 1'b0;
            cnt_rej_q   <= '0;
        end else begin
            state_q     <= state_d;
            pend_push_q <= pend_push_d;
            pend_pop_q  <= pend_pop_d;
            sel_q       <= sel_d;
            push_q      <= push_d;
            pop_q       <= pop_d;
            reject_q    <= reject_d;
            sticky_q    <= sticky_d;
            cnt_rej_q   <= cnt_rej_d;
        end
    end

    assign deque_select = sel_q;
    assign push         = push_q;
    assign pop          = pop_q;
    assign reject       = reject_q;
    assign err_sticky   = sticky_q;
    assign rej_count    = cnt_rej_q;
endmodule

// File: tb/tb_deque_cmd_conditioner.sv
// Directed bench for deque_cmd_conditioner with DEBOUNCE_CYCLES=4 and REJ_W=8.
module tb_deque_cmd_conditioner;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       raw_select = 1'b0, raw_push = 1'b0, raw_pop = 1'b0;
    logic       s0_full = 1'b0, s0_empty = 1'b0, s1_full = 1'b0, s1_empty = 1'b0;
    logic       err_clear = 1'b0;
    logic       deque_select, push, pop, reject, err_sticky;
    logic [7:0] rej_count;

    int n_checks = 0;
    int n_fail   = 0;

    deque_cmd_conditioner #(.DEBOUNCE_CYCLES(4), .REJ_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .raw_select(raw_select), .raw_push(raw_push), .raw_pop(raw_pop),
        .s0_full(s0_full), .s0_empty(s0_empty), .s1_full(s1_full), .s1_empty(s1_empty),
        .err_clear(err_clear),
        .deque_select(deque_select), .push(push), .pop(pop), .reject(reject),
        .err_sticky(err_sticky), .rej_count(rej_count)
    );

    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({deque_select, push, pop, reject, err_sticky, rej_count} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 0", {deque_select, push, pop, reject, err_sticky, rej_count});
        end
        rst_n = 1'b1;
        repeat (3) tick();
        $display("test_reset done");
    endtask

    task automatic test_push_latency();
        raw_push = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            n_checks++;
            if ({push, pop, reject} !== {(c == 8), 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL push_latency c=%0d: push/pop/reject got %b want %b", c, {push, pop, reject}, {(c == 8), 2'b00});
            end
        end
        raw_push = 1'b0;
        repeat (12) tick();
        $display("test_push_latency done");
    endtask

    task automatic test_glitch();
        raw_pop = 1'b1;
        repeat (3) tick();
        raw_pop = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            n_checks++;
            if ({pop, reject} !== 2'b00) begin
                n_fail++;
                $display("FAIL glitch c=%0d: pop/reject got %b want 00", c, {pop, reject});
            end
        end
        $display("test_glitch done");
    endtask

    task automatic test_reject_pop();
        raw_select = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            n_checks++;
            if (deque_select !== (c >= 8)) begin
                n_fail++;
                $display("FAIL select_follow c=%0d: got %b want %b", c, deque_select, (c >= 8));
            end
        end
        s1_empty = 1'b1;
        raw_pop = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            n_checks++;
            if ({pop, reject, push} !== {1'b0, (c == 8), 1'b0}) begin
                n_fail++;
                $display("FAIL reject_pop c=%0d: pop/reject/push got %b want %b", c, {pop, reject, push}, {1'b0, (c == 8), 1'b0});
            end
            if (c == 8) begin
                n_checks++;
                if ({err_sticky, rej_count} !== {1'b1, 8'd1}) begin
                    n_fail++;
                    $display("FAIL reject_err: sticky/count got %b/%0d want 1/1", err_sticky, rej_count);
                end
            end
        end
        raw_pop = 1'b0;
        repeat (10) tick();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        n_checks++;
        if ({err_sticky, rej_count} !== 9'd0) begin
            n_fail++;
            $display("FAIL err_clear: sticky/count got %b/%0d want 0/0", err_sticky, rej_count);
        end
        s1_empty = 1'b0;
        raw_select = 1'b0;
        repeat (12) tick();
        n_checks++;
        if (deque_select !== 1'b0) begin
            n_fail++;
            $display("FAIL select_return: got %b want 0", deque_select);
        end
        $display("test_reject_pop done");
    endtask

    task automatic test_back_to_back();
        raw_push = 1'b1;
        raw_pop  = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            n_checks++;
            if ({push, pop, reject, deque_select} !== {(c == 8), (c == 10), 2'b00}) begin
                n_fail++;
                $display("FAIL back_to_back c=%0d: push/pop/reject/sel got %b want %b", c, {push, pop, reject, deque_select}, {(c == 8), (c == 10), 2'b00});
            end
        end
        raw_push = 1'b0;
        raw_pop  = 1'b0;
        repeat (12) tick();
        $display("test_back_to_back done");
    endtask

    task automatic test_saturation();
        int rej_seen;
        rej_seen = 0;
        s0_full = 1'b1;
        for (int i = 0; i < 300; i++) begin
            raw_push = 1'b1;
            repeat (10) begin
                tick();
                if (reject === 1'b1) rej_seen++;
            end
            raw_push = 1'b0;
            repeat (10) begin
                tick();
                if (reject === 1'b1) rej_seen++;
            end
        end
        n_checks++;
        if (rej_seen != 300) begin
            n_fail++;
            $display("FAIL reject_pulses: got %0d want 300", rej_seen);
        end
        n_checks++;
        if ({err_sticky, rej_count} !== {1'b1, 8'd255}) begin
            n_fail++;
            $display("FAIL saturate: sticky/count got %b/%0d want 1/255", err_sticky, rej_count);
        end
        raw_push = 1'b1;
        repeat (7) tick();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        n_checks++;
        if ({reject, err_sticky, rej_count} !== {2'b11, 8'd1}) begin
            n_fail++;
            $display("FAIL clear_vs_reject: reject/sticky/count got %b/%b/%0d want 1/1/1", reject, err_sticky, rej_count);
        end
        tick();
        n_checks++;
        if ({reject, err_sticky, rej_count} !== {2'b01, 8'd1}) begin
            n_fail++;
            $display("FAIL clear_vs_reject_hold: reject/sticky/count got %b/%b/%0d want 0/1/1", reject, err_sticky, rej_count);
        end
        raw_push = 1'b0;
        s0_full  = 1'b0;
        repeat (12) tick();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        $display("test_saturation done");
    endtask

    task automatic test_reset_mid();
        raw_push = 1'b1;
        repeat (7) tick();
        rst_n = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            n_checks++;
            if ({deque_select, push, pop, reject, err_sticky, rej_count} !== 13'd0) begin
                n_fail++;
                $display("FAIL reset_mid c=%0d: outputs got %b want 0", c, {deque_select, push, pop, reject, err_sticky, rej_count});
            end
        end
        rst_n = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            n_checks++;
            if ({push, pop, reject} !== {(c == 8), 2'b00}) begin
                n_fail++;
                $display("FAIL reset_held c=%0d: push/pop/reject got %b want %b", c, {push, pop, reject}, {(c == 8), 2'b00});
            end
        end
        raw_push = 1'b0;
        repeat (12) tick();
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_push_latency();
        test_glitch();
        test_reject_pop();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
